seg14_msg_scroller: RTL and testbench
=====================================

SEG14_MSG_SCROLLER -- requirements
Module: seg14_msg_scroller

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 12000000, clock cycles per scroll step (legal range 2..2^24).
REQ-002 SHALL have parameter DEPTH, default 32, message buffer capacity in characters, fixed at 32.
REQ-003 SHALL have port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous reset, active-high.
REQ-005 SHALL have port wr_valid  in  1  character write request.
REQ-006 SHALL have port wr_ready  out  1  buffer accepts a character this cycle.
REQ-007 SHALL have port wr_char  in  6  character code.
REQ-008 SHALL have port wr_last  in  1  marks the accepted character as the end of the message.
REQ-009 SHALL have port clear  in  1  one-cycle pulse that discards the message.
REQ-010 SHALL have port scroll_en  in  1  enables scroll stepping.
REQ-011 SHALL have port digit_idx  in  4  digit requested by the downstream 12-digit scanner (0 = leftmost).
REQ-012 SHALL have port seg_data  out  14  14-segment pattern for the requested digit, bit 13 = segment a.
REQ-013 SHALL have port msg_len  out  6  number of stored characters (0..32).

Function
REQ-014 SHALL map codes as 0-9 digits, 10-35 A-Z, 36 space, 37 dash; codes 38-63 SHALL render as all-zero.
REQ-015 SHALL use glyphs: 0=11111100001001, 2=11011011000000, 3=11110001000000, A=11101111000000, B=11110001010010, E=10011110000000, L=00011100000000, N=01101100100100, O=11111100000000, P=11001111000000, space=0; remaining glyphs per the team 14-segment font table.
REQ-016 SHALL implement FSM states IDLE (empty), LOAD (receiving), SHOW (displaying).
REQ-017 SHALL drive wr_ready=1 in IDLE and LOAD and 0 in SHOW; a write SHALL be accepted when wr_valid and wr_ready are both 1.
REQ-018 SHALL store an accepted character at address msg_len, then increment msg_len; IDLE->LOAD on the first accept.
REQ-019 SHALL move to SHOW on an accept with wr_last=1, or on the 32nd accept regardless of wr_last.
REQ-020 SHALL, on clear, in any state, return to IDLE with msg_len=0, offset=0 and prescaler=0; clear SHALL win over a simultaneous write or scroll step, and that write SHALL be dropped.
REQ-021 SHALL keep a scroll offset (0..msg_len-1) and a prescaler; the prescaler SHALL count only in SHOW with scroll_en=1, and SHALL hold while scroll_en=0.
REQ-022 SHALL, in SHOW with msg_len>12, advance offset by 1 when the prescaler reaches STEP_CYCLES-1 (prescaler then returns to 0), wrapping offset from msg_len-1 to 0.
REQ-023 SHALL hold offset at 0 when msg_len<=12.
REQ-024 SHALL register seg_data one cycle after digit_idx (latency 1); a change in digit_idx SHALL be reflected on the next clock edge.
REQ-025 SHALL select char index (offset+digit_idx) mod msg_len when msg_len>12, using one conditional subtract on a 6-bit sum.
REQ-026 SHALL select char index digit_idx when msg_len<=12, and SHALL output 0 for digit_idx>=msg_len.
REQ-027 SHALL output seg_data=0 for digit_idx>=12, in IDLE, and in LOAD (display blank until SHOW).
REQ-028 SHALL reset the prescaler and offset to 0 on entry to SHOW.

Reset
REQ-029 SHALL, while rst=1, force seg_data=0, wr_ready=0, msg_len=0, offset=0, prescaler=0 and state=IDLE, independently of clk.
REQ-030 SHALL drive wr_ready=1 on the first clock edge after rst deasserts; buffer contents need not be cleared.
REQ-031 SHALL abandon any load or scroll in progress when rst is asserted mid-operation, with no partial message retained.

Verification (STEP_CYCLES=4)
REQ-032 SHALL verify: write P,A,B,E,L,L,O,N,2,0,2,3 (last on 3), digit_idx=0..11 -> seg_data P..3 per REQ-015 at 1-cycle latency; offset stays 0; wr_ready=0.
REQ-033 SHALL verify: 14-char message, scroll_en=1 -> offset steps every 4 cycles, 0..13 then back to 0; digit 11 at offset 3 shows char index 0.
REQ-034 SHALL verify: 32 writes without wr_last -> msg_len=32, state SHOW, 33rd wr_valid not accepted.
REQ-035 SHALL verify: clear coincident with wr_valid during LOAD -> msg_len=0, write dropped, seg_data=0 next cycle.
REQ-036 SHALL verify: rst pulse mid-scroll -> seg_data=0 and wr_ready=0 immediately; wr_ready=1 after release.
REQ-037 SHALL verify: scroll_en=0 for 10 cycles in SHOW -> offset unchanged; resumes from the held prescaler count.

Source files
------------

// File: rtl/seg14_msg_scroller.sv
// Message buffer and scroller for a 12-digit, 14-segment display.
// Characters are loaded into a 32-entry buffer. Once the message is
// complete it is shown, and messages longer than 12 characters scroll
// circularly.
module seg14_msg_scroller #(
  parameter int unsigned STEP_CYCLES = 12000000,
  parameter int unsigned DEPTH       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_char,
  input  logic        wr_last,
  input  logic        clear,
  input  logic        scroll_en,
  input  logic [3:0]  digit_idx,
  output logic [13:0] seg_data,
  output logic [5:0]  msg_len
);

  localparam int unsigned CW     = 6;   // character code width
  localparam int unsigned LW     = 6;   // length width (0..32)
  localparam int unsigned AW     = 5;   // buffer address width
  localparam int unsigned OW     = 5;   // scroll offset width
  localparam int unsigned PW     = 24;  // prescaler width
  localparam int unsigned SW     = 14;  // segment width
  localparam int unsigned DIGITS = 12;

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [OW-1:0]   off_q, off_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            rdy_q, rdy_d;
  logic [SW-1:0]   seg_q, seg_d;
  logic [CW-1:0]   mem_q [DEPTH];

  logic            wr_accept_c;
  logic [LW-1:0]   sum_c;
  logic [AW-1:0]   idx_c;

  // Glyph lookup: bit 13 = a, then b c d e f g1 g2 h i j k l m.
  function automatic logic [SW-1:0] glyph(input logic [CW-1:0] code);
    case (code)
      6'd0:  glyph = 14'b11111100001001;
      6'd1:  glyph = 14'b01100000001000;
      6'd2:  glyph = 14'b11011011000000;
      6'd3:  glyph = 14'b11110001000000;
      6'd4:  glyph = 14'b01100111000000;
      6'd5:  glyph = 14'b10110111000000;
      6'd6:  glyph = 14'b10111111000000;
      6'd7:  glyph = 14'b11100000000000;
      6'd8:  glyph = 14'b11111111000000;
      6'd9:  glyph = 14'b11110111000000;
      6'd10: glyph = 14'b11101111000000;
      6'd11: glyph = 14'b11110001010010;
      6'd12: glyph = 14'b10011100000000;
      6'd13: glyph = 14'b11110000010010;
      6'd14: glyph = 14'b10011110000000;
      6'd15: glyph = 14'b10001110000000;
      6'd16: glyph = 14'b10111101000000;
      6'd17: glyph = 14'b01101111000000;
      6'd18: glyph = 14'b10010000010010;
      6'd19: glyph = 14'b01111000000000;
      6'd20: glyph = 14'b00001110001100;
      6'd21: glyph = 14'b00011100000000;
      6'd22: glyph = 14'b01101100101000;
      6'd23: glyph = 14'b01101100100100;
      6'd24: glyph = 14'b11111100000000;
      6'd25: glyph = 14'b11001111000000;
      6'd26: glyph = 14'b11111100000100;
      6'd27: glyph = 14'b11001111000100;
      6'd28: glyph = 14'b10110111000000;
      6'd29: glyph = 14'b10000000010010;
      6'd30: glyph = 14'b01111100000000;
      6'd31: glyph = 14'b00001100001001;
      6'd32: glyph = 14'b01101100000101;
      6'd33: glyph = 14'b00000000101101;
      6'd34: glyph = 14'b00000000101010;
      6'd35: glyph = 14'b10010000001001;
      6'd37: glyph = 14'b00000011000000;
      default: glyph = '0;
    endcase
  endfunction

  // A write is taken only while ready; clear drops a coincident write.
  assign wr_accept_c = wr_valid && rdy_q && !clear;

  // Next-state logic for the FSM, length, scroll offset and prescaler.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    off_d   = off_q;
    presc_d = presc_q;
    if (clear) begin
      state_d = IDLE;
      len_d   = '0;
      off_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (wr_accept_c) begin
            len_d   = len_q + LW'(1);
            state_d = LOAD;
            if (wr_last || (len_q == LW'(DEPTH - 1))) begin
              state_d = SHOW;
              off_d   = '0;
              presc_d = '0;
            end
          end
        end
        SHOW: begin
          if (scroll_en) begin
            if (presc_q == PW'(STEP_CYCLES - 1)) begin
              presc_d = '0;
              if (len_q > LW'(DIGITS)) begin
                off_d = ((LW'(off_q) + LW'(1)) == len_q) ? '0 : off_q + OW'(1);
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Ready tracks the upcoming state, so it rises one edge after reset.
  assign rdy_d = (state_d != SHOW);

  // Character selection and glyph for the requested digit.
  always_comb begin
    seg_d = '0;
    sum_c = LW'(off_q) + LW'(digit_idx);
    if (len_q > LW'(DIGITS)) begin
      // offset < len and digit < 12 < len, so one subtract wraps the sum
      idx_c = (sum_c >= len_q) ? AW'(sum_c - len_q) : AW'(sum_c);
    end else begin
      idx_c = AW'(digit_idx);
    end
    if ((state_q == SHOW) && (digit_idx < 4'(DIGITS)) &&
        ((len_q > LW'(DIGITS)) || (LW'(digit_idx) < len_q))) begin
      seg_d = glyph(mem_q[idx_c]);
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      off_q   <= '0;
      presc_q <= '0;
      rdy_q   <= 1'b0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      off_q   <= off_d;
      presc_q <= presc_d;
      rdy_q   <= rdy_d;
      seg_q   <= seg_d;
    end
  end

  // Message storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      mem_q[len_q[AW-1:0]] <= wr_char;
    end
  end

  assign wr_ready = rdy_q;
  assign seg_data = seg_q;
  assign msg_len  = len_q;

endmodule

// File: tb/tb_seg14_msg_scroller.sv
// Self-checking bench for seg14_msg_scroller with a queue-based reference model.
module tb_seg14_msg_scroller;

  localparam int unsigned STEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_char;
  logic        wr_last;
  logic        clear;
  logic        scroll_en;
  logic [3:0]  digit_idx;
  logic [13:0] seg_data;
  logic [5:0]  msg_len;

  seg14_msg_scroller #(.STEP_CYCLES(STEP), .DEPTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_char   (wr_char),
    .wr_last   (wr_last),
    .clear     (clear),
    .scroll_en (scroll_en),
    .digit_idx (digit_idx),
    .seg_data  (seg_data),
    .msg_len   (msg_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stored message, showing flag, enabled cycles in SHOW.
  logic [5:0] msg[$];
  bit         m_show;
  bit         m_rdy;
  int         en_cnt;

  logic [5:0] pool [13] = '{6'd0, 6'd2, 6'd3, 6'd10, 6'd11, 6'd14, 6'd21,
                            6'd23, 6'd24, 6'd25, 6'd36, 6'd40, 6'd63};

  // Glyphs with a known pattern; codes 36 and 38..63 are blank.
  function automatic logic [13:0] font(input logic [5:0] c);
    case (c)
      6'd0:  return 14'b11111100001001;
      6'd2:  return 14'b11011011000000;
      6'd3:  return 14'b11110001000000;
      6'd10: return 14'b11101111000000;
      6'd11: return 14'b11110001010010;
      6'd14: return 14'b10011110000000;
      6'd21: return 14'b00011100000000;
      6'd23: return 14'b01101100100100;
      6'd24: return 14'b11111100000000;
      6'd25: return 14'b11001111000000;
      default: return 14'b0;
    endcase
  endfunction

  function automatic logic [5:0] pick(input bit nonblank);
    return pool[$urandom_range(0, nonblank ? 9 : 12)];
  endfunction

  // Expected display for digit d from the model's current state.
  function automatic logic [13:0] exp_seg(input logic [3:0] d);
    int len, off, di;
    len = msg.size();
    di  = int'(d);
    if (!m_show || di >= 12) return 14'b0;
    if (len > 12) begin
      off = (en_cnt / STEP) % len;
      return font(msg[(off + di) % len]);
    end
    if (di >= len) return 14'b0;
    return font(msg[di]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: predict from pre-edge state, advance model, compare after edge.
  task automatic cycle();
    logic [13:0] es;
    bit acc;
    es  = exp_seg(digit_idx);
    acc = wr_valid && m_rdy && !clear;
    if (clear) begin
      msg.delete();
      m_show = 1'b0;
      en_cnt = 0;
    end else if (acc) begin
      msg.push_back(wr_char);
      if (wr_last || msg.size() == 32) begin
        m_show = 1'b1;
        en_cnt = 0;
      end
    end else if (m_show && scroll_en) begin
      en_cnt++;
    end
    m_rdy = !m_show;
    @(posedge clk);
    #1;
    check("seg_data", 32'(seg_data), 32'(es));
    check("msg_len", 32'(msg_len), 32'(msg.size()));
    check("wr_ready", 32'(wr_ready), 32'(m_rdy));
  endtask

  task automatic wr(input logic [5:0] c, input bit last);
    wr_valid = 1'b1;
    wr_char  = c;
    wr_last  = last;
    cycle();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      digit_idx = 4'($urandom_range(0, 15));
      cycle();
    end
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_seg", 32'(seg_data), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_len", 32'(msg_len), 32'd0);
    msg.delete();
    m_show = 1'b0;
    m_rdy  = 1'b0;
    en_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [5:0] demo [12] = '{6'd25, 6'd10, 6'd11, 6'd14, 6'd21, 6'd21,
                            6'd24, 6'd23, 6'd2, 6'd0, 6'd2, 6'd3};

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_char = '0; wr_last = 1'b0;
    clear = 1'b0; scroll_en = 1'b0; digit_idx = '0;
    m_show = 1'b0; m_rdy = 1'b0; en_cnt = 0;

    // Reset state.
    #12;
    check("reset_seg", 32'(seg_data), 32'd0);
    check("reset_ready", 32'(wr_ready), 32'd0);
    check("reset_len", 32'(msg_len), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("ready_after_reset", 32'(wr_ready), 32'd1);

    // Twelve-character message: static display, no scroll, writes refused.
    for (int i = 0; i < 12; i++) wr(demo[i], i == 11);
    scroll_en = 1'b1;
    for (int d = 0; d < 12; d++) begin
      digit_idx = 4'(d);
      cycle();
      check("demo_glyph", 32'(seg_data), 32'(font(demo[d])));
    end
    wr_valid = 1'b1; wr_char = 6'd2;
    cycle(); cycle();
    wr_valid = 1'b0;
    scan(12);

    // Fourteen characters: scroll, wrap, digit 11 at offset 3 shows char 0.
    pulse_clear();
    wr(6'd25, 1'b0);
    for (int i = 1; i < 14; i++) wr(pick(1'b1), i == 13);
    for (int i = 0; i < 20 && en_cnt != 12; i++) scan(1);
    digit_idx = 4'd11;
    cycle();
    check("wrap_digit11", 32'(seg_data), 32'(font(msg[0])));
    scan(60);

    // Scroll pause holds the prescaler, then resumes.
    scroll_en = 1'b0;
    scan(10);
    scroll_en = 1'b1;
    scan(20);

    // Reset in the middle of scrolling.
    do_reset();
    cycle();
    check("ready_after_midreset", 32'(wr_ready), 32'd1);

    // Full buffer without a last marker; extra write not accepted.
    for (int i = 0; i < 32; i++) wr(pick(1'b0), 1'b0);
    check("full_len", 32'(msg_len), 32'd32);
    wr_valid = 1'b1; wr_char = 6'd3;
    cycle(); cycle(); cycle();
    wr_valid = 1'b0;
    scan(80);

    // Clear colliding with a write during load.
    pulse_clear();
    for (int i = 0; i < 3; i++) wr(pick(1'b1), 1'b0);
    wr_valid = 1'b1; wr_char = 6'd11; clear = 1'b1;
    cycle();
    wr_valid = 1'b0; clear = 1'b0;
    check("clear_len", 32'(msg_len), 32'd0);
    cycle();
    check("clear_seg", 32'(seg_data), 32'd0);
    for (int i = 0; i < 13; i++) wr(pick(1'b1), i == 12);
    scan(30);
    clear = 1'b1; wr_valid = 1'b1;
    cycle();
    clear = 1'b0; wr_valid = 1'b0;
    scan(4);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      wr_valid  = 1'($urandom_range(0, 1));
      wr_char   = pick(1'b0);
      wr_last   = ($urandom_range(0, 9) == 0);
      clear     = ($urandom_range(0, 60) == 0);
      scroll_en = ($urandom_range(0, 3) != 0);
      digit_idx = 4'($urandom_range(0, 15));
      cycle();
    end
    wr_valid = 1'b0; clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
